// File: rtl/wb_master_arbiter_if.sv
// Requester-side and Wishbone-side signals of the two-master Wishbone arbiter.
interface wb_master_arbiter_if;
  logic        m0_valid;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m0_ready;
  logic [31:0] m0_rdata;

  logic        m1_valid;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_ready;
  logic [31:0] m1_rdata;

  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_stb_o;
  logic        wbm_cyc_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m0_ready, m0_rdata,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
    output m1_ready, m1_rdata,
    output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m0_ready, m0_rdata,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb,
    input  m1_ready, m1_rdata,
    input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter of two requesters onto one Wishbone classic master port.
// Optional BUS-state watchdog enabled by defining WB_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no cycle in flight; arbitrate pending requests
// BUS   | cyc/stb asserted for the owner, waiting for ack (or timeout)
// DONE  | one-cycle ready pulse to the owner; all requests ignored
module wb_master_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clock_main,
  input  logic                rst,
  wb_master_arbiter_if.master bus,
  output logic [1:0]          grant_o,
  output logic                timeout_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        owner, last_grant, winner;
  logic        grant_en, ack_done, tmo_done, tmo_hit;
  logic [31:0] rdata_q;
  logic [31:0] adr_q, dat_q;
  logic        we_q, stb_q, cyc_q;
  logic [3:0]  sel_q;
  logic [31:0] win_addr, win_wdata;
  logic [3:0]  win_wstrb;

  // On a tie the requester that did not win last time takes the bus.
  always_comb begin
    winner = bus.m1_valid;
    if (bus.m0_valid && bus.m1_valid) winner = ~last_grant;
  end

  assign win_addr  = winner ? bus.m1_addr  : bus.m0_addr;
  assign win_wdata = winner ? bus.m1_wdata : bus.m0_wdata;
  assign win_wstrb = winner ? bus.m1_wstrb : bus.m0_wstrb;

  always_ff @(posedge clock_main) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    ack_done  = 1'b0;
    tmo_done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.m0_valid || bus.m1_valid) begin
          grant_en  = 1'b1;
          state_nxt = BUS;
        end
      end
      BUS: begin
        if (bus.wbm_ack_i) begin
          ack_done  = 1'b1;
          state_nxt = DONE;
        end else if (tmo_hit) begin
          tmo_done  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_main) begin
    if (rst) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      stb_q      <= 1'b0;
      cyc_q      <= 1'b0;
      rdata_q    <= '0;
    end else if (grant_en) begin
      owner      <= winner;
      last_grant <= winner;
      adr_q      <= win_addr;
      dat_q      <= win_wdata;
      we_q       <= |win_wstrb;
      sel_q      <= (|win_wstrb) ? win_wstrb : 4'b1111;
      stb_q      <= 1'b1;
      cyc_q      <= 1'b1;
    end else if (ack_done || tmo_done) begin
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
      rdata_q <= ack_done ? bus.wbm_dat_i : 32'hDEAD_BEEF;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_flag;

  // Counter sits at zero outside BUS, so it is cleared on every entry.
  always_ff @(posedge clock_main) begin
    if (rst || state != BUS) tmo_cnt <= '0;
    else                     tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock_main) begin
    if (rst)           tmo_flag <= 1'b0;
    else if (grant_en) tmo_flag <= 1'b0;
    else if (tmo_done) tmo_flag <= 1'b1;
  end

  assign timeout_o = ~rst & (state == DONE) & tmo_flag;
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_stb_o = stb_q;
  assign bus.wbm_cyc_o = cyc_q;

  assign bus.m0_ready = ~rst & (state == DONE) & ~owner;
  assign bus.m1_ready = ~rst & (state == DONE) &  owner;
  assign bus.m0_rdata = bus.m0_ready ? rdata_q : 32'h0;
  assign bus.m1_rdata = bus.m1_ready ? rdata_q : 32'h0;

  assign grant_o = (rst || state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed self-checking bench for wb_master_arbiter (TIMEOUT_CYCLES = 8).
// Timeout scenarios run only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_master_arbiter;

  logic       clock_main;
  logic       rst;
  logic [1:0] grant_o;
  logic       timeout_o;
  int         n_checks = 0;
  int         n_fail   = 0;

  wb_master_arbiter_if bus ();

  wb_master_arbiter #(.TIMEOUT_CYCLES(8)) u_dut (
    .clock_main (clock_main),
    .rst        (rst),
    .bus        (bus),
    .grant_o    (grant_o),
    .timeout_o  (timeout_o)
  );

  initial clock_main = 1'b0;
  always #5 clock_main = ~clock_main;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock_main)
    if (bus.m0_ready && bus.m1_ready)
      check_val("dual_ready", {30'h0, bus.m1_ready, bus.m0_ready}, 32'h1);

  task automatic set_req(input bit n, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    if (!n) begin
      bus.m0_valid = v; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_wstrb = s;
    end else begin
      bus.m1_valid = v; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_wstrb = s;
    end
  endtask

  // Full transfer: ack becomes visible in BUS cycle ack_dly, ready expected the cycle after.
  task automatic xfer(input bit n, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int ack_dly, input logic [31:0] sdat);
    logic [3:0] exp_sel;
    logic [1:0] exp_grant;
    exp_sel   = (s != 4'h0) ? s : 4'hF;
    exp_grant = n ? 2'b10 : 2'b01;
    @(posedge clock_main); #1;
    set_req(n, 1'b1, a, d, s);
    @(posedge clock_main);
    @(negedge clock_main);
    check_val("bus_cyc",   bus.wbm_cyc_o, 1);
    check_val("bus_stb",   bus.wbm_stb_o, 1);
    check_val("bus_we",    bus.wbm_we_o,  {31'h0, |s});
    check_val("bus_sel",   bus.wbm_sel_o, exp_sel);
    check_val("bus_adr",   bus.wbm_adr_o, a);
    check_val("bus_grant", grant_o,       exp_grant);
    if (s != 4'h0) check_val("bus_dat", bus.wbm_dat_o, d);
    for (int i = 1; i < ack_dly; i++) begin
      @(posedge clock_main);
      @(negedge clock_main);
      check_val("hold_cyc", bus.wbm_cyc_o, 1);
      check_val("hold_adr", bus.wbm_adr_o, a);
      check_val("hold_rdy", {30'h0, bus.m1_ready, bus.m0_ready}, 0);
    end
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = sdat;
    @(posedge clock_main); #1;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'h0;
    @(negedge clock_main);
    check_val("done_cyc",     bus.wbm_cyc_o, 0);
    check_val("done_stb",     bus.wbm_stb_o, 0);
    check_val("done_we",      bus.wbm_we_o,  0);
    check_val("done_rdy",     n ? bus.m1_ready : bus.m0_ready, 1);
    check_val("done_rdata",   n ? bus.m1_rdata : bus.m0_rdata, sdat);
    check_val("other_rdy",    n ? bus.m0_ready : bus.m1_ready, 0);
    check_val("other_rdata",  n ? bus.m0_rdata : bus.m1_rdata, 0);
    check_val("done_timeout", timeout_o, 0);
    check_val("done_grant",   grant_o, exp_grant);
    @(posedge clock_main); #1;
    set_req(n, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clock_main);
    check_val("idle_rdy",   {30'h0, bus.m1_ready, bus.m0_ready}, 0);
    check_val("idle_grant", grant_o, 0);
  endtask

  initial begin
    int cnt0, cnt1;
    bit lost;
    rst = 1'b1;
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'h0;
    repeat (3) @(posedge clock_main);
    @(negedge clock_main);
    check_val("rst_cyc",     bus.wbm_cyc_o, 0);
    check_val("rst_stb",     bus.wbm_stb_o, 0);
    check_val("rst_adr",     bus.wbm_adr_o, 0);
    check_val("rst_sel",     bus.wbm_sel_o, 0);
    check_val("rst_grant",   grant_o, 0);
    check_val("rst_timeout", timeout_o, 0);
    check_val("rst_rdy",     {30'h0, bus.m1_ready, bus.m0_ready}, 0);
    check_val("rst_rdata",   bus.m0_rdata | bus.m1_rdata, 0);
    rst = 1'b0;

    xfer(0, 32'h0300_0010, 32'h0, 4'b0000, 4, 32'h1234_5678);
    xfer(1, 32'h0400_0020, 32'hA5A5_0001, 4'b0011, 2, 32'h0);

`ifdef WB_ARB_TIMEOUT_EN
    // No ack: eight BUS cycles, then abort with the filler data.
    @(posedge clock_main); #1;
    set_req(0, 1'b1, 32'h0300_0040, 32'h0, 4'h0);
    @(posedge clock_main);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock_main);
      check_val("tmo_hold_cyc", bus.wbm_cyc_o, 1);
      check_val("tmo_hold_pulse", timeout_o, 0);
      @(posedge clock_main);
    end
    @(negedge clock_main);
    check_val("tmo_cyc",   bus.wbm_cyc_o, 0);
    check_val("tmo_stb",   bus.wbm_stb_o, 0);
    check_val("tmo_pulse", timeout_o, 1);
    check_val("tmo_rdy",   bus.m0_ready, 1);
    check_val("tmo_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
    @(posedge clock_main); #1;
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clock_main);
    check_val("tmo_pulse_end", timeout_o, 0);
    check_val("tmo_rdy_end",   bus.m0_ready, 0);
    // Ack in the 8th BUS cycle wins over the timeout.
    xfer(0, 32'h0300_0044, 32'h0, 4'h0, 8, 32'h0BAD_F00D);
`else
    // Without the watchdog a slow slave is simply waited for.
    xfer(0, 32'h0300_0048, 32'h0, 4'h0, 30, 32'hCAFE_0001);
`endif

    // Round robin: both requesting continuously, four transfers each.
    @(posedge clock_main); #1;
    rst = 1'b1;
    @(posedge clock_main); #1;
    rst = 1'b0;
    set_req(0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
    set_req(1, 1'b1, 32'h0000_0200, 32'h0, 4'h0);
    cnt0 = 0;
    cnt1 = 0;
    lost = 1'b0;
    for (int t = 0; t < 8 && !lost; t++) begin
      int k;
      k = 0;
      do begin
        @(negedge clock_main);
        k++;
      end while (!bus.wbm_cyc_o && k < 20);
      if (!bus.wbm_cyc_o) begin
        check_val("rr_wait_cyc", bus.wbm_cyc_o, 1);
        lost = 1'b1;
      end else begin
        check_val("rr_grant",  grant_o, (t % 2) ? 2'b10 : 2'b01);
        check_val("rr_onehot", $countones(grant_o), 1);
        check_val("rr_adr",    bus.wbm_adr_o, (t % 2) ? 32'h0000_0200 : 32'h0000_0100);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h5000_0000 + t;
        @(posedge clock_main); #1;
        bus.wbm_ack_i = 1'b0;
        @(negedge clock_main);
        check_val("rr_rdy", (t % 2) ? bus.m1_ready : bus.m0_ready, 1);
        check_val("rr_other_rdy", (t % 2) ? bus.m0_ready : bus.m1_ready, 0);
        if (bus.m0_ready) cnt0++;
        if (bus.m1_ready) cnt1++;
        @(posedge clock_main); #1;
        if (cnt0 == 4) bus.m0_valid = 1'b0;
        if (cnt1 == 4) bus.m1_valid = 1'b0;
      end
    end
    check_val("rr_count_m0", cnt0, 4);
    check_val("rr_count_m1", cnt1, 4);
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);

    // m0 goes last, so without reset a tie would go to m1.
    xfer(0, 32'h0300_0050, 32'h0, 4'h0, 1, 32'h7777_0000);
    @(posedge clock_main); #1;
    set_req(0, 1'b1, 32'h0300_0054, 32'h0, 4'h0);
    @(posedge clock_main);
    @(negedge clock_main);
    check_val("rstbus_cyc_pre", bus.wbm_cyc_o, 1);
    rst = 1'b1;
    @(posedge clock_main);
    @(negedge clock_main);
    check_val("rstbus_cyc",   bus.wbm_cyc_o, 0);
    check_val("rstbus_stb",   bus.wbm_stb_o, 0);
    check_val("rstbus_rdy",   bus.m0_ready, 0);
    check_val("rstbus_grant", grant_o, 0);
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst = 1'b0;
    @(posedge clock_main);
    @(negedge clock_main);
    check_val("rstbus_rdy_after", {30'h0, bus.m1_ready, bus.m0_ready}, 0);
    set_req(0, 1'b1, 32'h0300_0058, 32'h0, 4'h0);
    set_req(1, 1'b1, 32'h0400_0058, 32'h0, 4'h0);
    @(posedge clock_main);
    @(negedge clock_main);
    check_val("rstbus_first_grant", grant_o, 2'b01);
    check_val("rstbus_first_adr",   bus.wbm_adr_o, 32'h0300_0058);
    bus.wbm_ack_i = 1'b1;
    @(posedge clock_main); #1;
    bus.wbm_ack_i = 1'b0;
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clock_main);
    check_val("rstbus_first_rdy", bus.m0_ready, 1);
    @(posedge clock_main); #1;
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clock_main);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
